// File: rtl/leaf_rr_dispatcher_if.sv
// Work-item handshake bundle between the upstream stream, the dispatcher and its leaves.
// master = environment side (source + leaves), slave = dispatcher side.
interface leaf_rr_dispatcher_if #(
    parameter int NUM_LEAVES = 5,
    parameter int DATA_W     = 32
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_W-1:0]     s_data;
    logic [NUM_LEAVES-1:0] m_valid;
    logic [NUM_LEAVES-1:0] m_ready;
    logic [DATA_W-1:0]     m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/leaf_rr_dispatcher.sv
// Round-robin dispatcher: hands each input item to one leaf, skipping leaves that
// already hold MAX_OUT unretired items. Single registered output stage.
module leaf_rr_dispatcher #(
    parameter int NUM_LEAVES = 5,
    parameter int DATA_W     = 32,
    parameter int MAX_OUT    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    leaf_rr_dispatcher_if.slave   bus,
    input  logic [NUM_LEAVES-1:0] leaf_done,
    output logic                  busy,
    output logic [CNT_W-1:0]      dispatch_cnt,
    output logic                  err_underflow
);
    localparam int IDX_W  = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
    localparam int OCNT_W = $clog2(MAX_OUT + 1);

    logic                  out_vld_reg;
    logic [IDX_W-1:0]      out_idx_reg;
    logic [DATA_W-1:0]     out_data_reg;
    logic [IDX_W-1:0]      last_grant_reg;
    logic [CNT_W-1:0]      dispatch_cnt_reg;
    logic                  err_underflow_reg;

    logic [NUM_LEAVES-1:0] eligible;
    logic [NUM_LEAVES-1:0] nonzero;
    logic [NUM_LEAVES-1:0] underflow;
    logic [NUM_LEAVES-1:0] m_valid_vec;
    logic [IDX_W-1:0]      sel;
    logic                  found;
    logic                  any_eligible;
    logic                  out_fire;
    logic                  s_ready_int;
    logic                  accept;

    // Scan starts just after the last grant so every leaf gets a fair turn.
    always_comb begin : grant_scan
        int cand;
        cand  = 0;
        sel   = last_grant_reg;
        found = 1'b0;
        for (int k = 1; k <= NUM_LEAVES; k++) begin
            cand = int'(last_grant_reg) + k;
            if (cand >= NUM_LEAVES) begin
                cand = cand - NUM_LEAVES;
            end
            if (!found && eligible[cand[IDX_W-1:0]]) begin
                sel   = IDX_W'(cand);
                found = 1'b1;
            end
        end
    end

    // m_valid is one-hot, so the held item fires only on its own leaf's ready.
    assign out_fire     = |(m_valid_vec & bus.m_ready);
    assign any_eligible = |eligible;
    assign s_ready_int  = any_eligible & (~out_vld_reg | out_fire);
    assign accept       = bus.s_valid & s_ready_int;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEAVES; gi++) begin : g_leaf
            logic [OCNT_W-1:0] outstanding_reg;
            logic              inc;

            assign inc             = accept & (sel == IDX_W'(gi));
            assign eligible[gi]    = outstanding_reg < OCNT_W'(MAX_OUT);
            assign nonzero[gi]     = outstanding_reg != '0;
            assign m_valid_vec[gi] = out_vld_reg & (out_idx_reg == IDX_W'(gi));
            // A retire arriving with a same-cycle accept cancels it, so it cannot underflow.
            assign underflow[gi]   = leaf_done[gi] & ~inc & ~nonzero[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    outstanding_reg <= '0;
                end else if (inc && !leaf_done[gi]) begin
                    outstanding_reg <= outstanding_reg + OCNT_W'(1);
                end else if (leaf_done[gi] && !inc && nonzero[gi]) begin
                    outstanding_reg <= outstanding_reg - OCNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_reg       <= 1'b0;
            out_idx_reg       <= '0;
            out_data_reg      <= '0;
            last_grant_reg    <= IDX_W'(NUM_LEAVES - 1);
            dispatch_cnt_reg  <= '0;
            err_underflow_reg <= 1'b0;
        end else begin
            if (accept) begin
                out_vld_reg      <= 1'b1;
                out_idx_reg      <= sel;
                out_data_reg     <= bus.s_data;
                last_grant_reg   <= sel;
                dispatch_cnt_reg <= dispatch_cnt_reg + CNT_W'(1);
            end else if (out_fire) begin
                out_vld_reg <= 1'b0;
            end
            if (|underflow) begin
                err_underflow_reg <= 1'b1;
            end
        end
    end

    assign bus.s_ready   = s_ready_int;
    assign bus.m_valid   = m_valid_vec;
    assign bus.m_data    = out_data_reg;
    assign busy          = |nonzero;
    assign dispatch_cnt  = dispatch_cnt_reg;
    assign err_underflow = err_underflow_reg;
endmodule

// File: tb/tb_leaf_rr_dispatcher.sv
// Bench for leaf_rr_dispatcher: per-cycle comparison against a behavioural model plus
// directed scenarios with literal expectations; a CNT_W=4 twin checks counter wrap.
module tb_leaf_rr_dispatcher;
    localparam int N    = 5;
    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  leaf_done;
    logic          busy, busy4, err, err4;
    logic [15:0]   cnt;
    logic [3:0]    cnt4;

    int checks = 0;
    int failures = 0;
    int fire_log[$];

    leaf_rr_dispatcher_if #(.NUM_LEAVES(N), .DATA_W(DW)) bus ();
    leaf_rr_dispatcher_if #(.NUM_LEAVES(N), .DATA_W(DW)) bus4 ();

    assign bus4.s_valid = bus.s_valid;
    assign bus4.s_data  = bus.s_data;
    assign bus4.m_ready = bus.m_ready;

    leaf_rr_dispatcher #(.NUM_LEAVES(N), .DATA_W(DW), .MAX_OUT(MAXO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .leaf_done(leaf_done),
        .busy(busy), .dispatch_cnt(cnt), .err_underflow(err)
    );

    leaf_rr_dispatcher #(.NUM_LEAVES(N), .DATA_W(DW), .MAX_OUT(MAXO), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .leaf_done(leaf_done),
        .busy(busy4), .dispatch_cnt(cnt4), .err_underflow(err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model state: per-leaf outstanding counts, last granted leaf, held item, totals.
    int           m_cnt[N];
    int           m_last;
    bit           m_hv;
    int           m_hi;
    logic [DW-1:0] m_hd;
    int           m_total;
    bit           m_err;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_last  = N - 1;
        m_hv    = 0;
        m_hi    = 0;
        m_hd    = '0;
        m_total = 0;
        m_err   = 0;
    endfunction

    always @(negedge clk) begin
        bit           elig, fire, exp_ready, acc, inc, any_busy;
        int           pick, c;
        logic [N-1:0] exp_mv;
        if (!rst_n) model_reset();
        exp_mv   = m_hv ? (N'(1) << m_hi) : '0;
        fire     = m_hv && bus.m_ready[m_hi];
        elig     = 0;
        any_busy = 0;
        for (int i = 0; i < N; i++) begin
            if (m_cnt[i] < MAXO) elig = 1;
            if (m_cnt[i] != 0) any_busy = 1;
        end
        exp_ready = elig && (!m_hv || fire);
        chk("m_valid", bus.m_valid, exp_mv);
        chk("m_data", bus.m_data, m_hd);
        chk("s_ready", bus.s_ready, exp_ready);
        chk("busy", busy, any_busy);
        chk("dispatch_cnt", cnt, 64'(m_total % 65536));
        chk("err_underflow", err, m_err);
        chk("m_valid_w4", bus4.m_valid, exp_mv);
        chk("dispatch_cnt_w4", cnt4, 64'(m_total % 16));
        for (int i = 0; i < N; i++) begin
            if (bus.m_valid[i] && bus.m_ready[i]) fire_log.push_back(i);
        end
        if (rst_n) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (pick < 0 && m_cnt[c] < MAXO) pick = c;
            end
            acc = bus.s_valid && exp_ready;
            for (int i = 0; i < N; i++) begin
                inc = acc && (pick == i);
                if (leaf_done[i] && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1;
                    else m_cnt[i]--;
                end else if (inc && !leaf_done[i]) begin
                    m_cnt[i]++;
                end
            end
            if (acc) begin
                m_hv = 1; m_hi = pick; m_hd = bus.s_data; m_last = pick; m_total++;
            end else if (fire) begin
                m_hv = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        leaf_done = '0;
        bus.m_ready = '1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fire_log.delete();
    endtask

    // Offers d until accepted or max_cyc cycles pass; leaves s_valid asserted.
    task automatic send(input logic [DW-1:0] d, input int max_cyc, output bit ok);
        ok = 0;
        bus.s_valid = 1'b1;
        bus.s_data = d;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n_acc;
        int exp1[7];
        exp1 = '{0, 1, 2, 3, 4, 0, 1};
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = '1;
        leaf_done = '0;
        do_reset();

        // 1: straight round-robin stream
        for (int i = 0; i < 7; i++) begin
            send(32'hD000_0000 + i, 4, ok);
            chk("t1_accept", ok, 1);
        end
        bus.s_valid = 1'b0;
        tick(); tick();
        chk("t1_cnt", cnt, 7);
        chk("t1_nfires", fire_log.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < fire_log.size()) chk("t1_leaf_order", fire_log[i], exp1[i]);
        end

        // 2: all leaves saturate, a retire reopens leaf 3
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            send(32'hA0 + i, 4, ok);
            if (ok) n_acc++;
        end
        chk("t2_accepted", n_acc, 10);
        send(32'hAB, 4, ok);
        chk("t2_11th_refused", ok, 0);
        chk("t2_s_ready_low", bus.s_ready, 0);
        leaf_done = 5'b01000;
        tick();
        leaf_done = '0;
        send(32'hAB, 4, ok);
        chk("t2_after_done", ok, 1);
        bus.s_valid = 1'b0;
        tick();
        chk("t2_nfires", fire_log.size(), 11);
        if (fire_log.size() > 0) chk("t2_leaf3", fire_log[$], 3);

        // 3: held item waits on its own leaf's ready
        do_reset();
        bus.m_ready = 5'b11110;
        send(32'h3333_0000, 4, ok);
        chk("t3_accept", ok, 1);
        bus.s_data = 32'h3333_0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", bus.m_valid, 5'b00001);
            chk("t3_hold_data", bus.m_data, 32'h3333_0000);
            chk("t3_hold_ready", bus.s_ready, 0);
            @(posedge clk); #1;
        end
        bus.m_ready = '1;
        @(negedge clk);
        chk("t3_ready_on_fire", bus.s_ready, 1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        chk("t3_next_valid", bus.m_valid, 5'b00010);
        chk("t3_next_data", bus.m_data, 32'h3333_0001);
        tick(); tick();

        // 4: underflow sticky; retire and accept on leaf 2 in one cycle cancel
        do_reset();
        leaf_done = 5'b10000;
        tick();
        leaf_done = '0;
        chk("t4_err_set", err, 1);
        for (int i = 0; i < 7; i++) send(32'h4444_0000 + i, 4, ok);
        bus.s_data = 32'h4444_0007;
        leaf_done = 5'b00100;
        @(negedge clk);
        chk("t4_ready_same_cycle", bus.s_ready, 1);
        @(posedge clk); #1;
        leaf_done = '0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            send(32'h4444_0010 + i, 3, ok);
            if (ok) n_acc++;
        end
        chk("t4_accepted_after", n_acc, 3);
        bus.s_valid = 1'b0;
        tick(); tick();
        chk("t4_err_sticky", err, 1);

        // 5: async reset while leaf 2 holds an item
        do_reset();
        leaf_done = 5'b00010;
        tick();
        leaf_done = '0;
        chk("t5_err_pre", err, 1);
        bus.m_ready = 5'b11011;
        send(32'h5555_0000, 4, ok);
        send(32'h5555_0001, 4, ok);
        send(32'h5555_0002, 4, ok);
        bus.s_valid = 1'b0;
        chk("t5_held_leaf2", bus.m_valid, 5'b00100);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_mvalid", bus.m_valid, 0);
        chk("t5_rst_mdata", bus.m_data, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cnt", cnt, 0);
        chk("t5_rst_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.m_ready = '1;
        send(32'h5555_00FF, 4, ok);
        chk("t5_post_accept", ok, 1);
        chk("t5_post_leaf0", bus.m_valid, 5'b00001);
        chk("t5_post_data", bus.m_data, 32'h5555_00FF);
        bus.s_valid = 1'b0;
        tick();

        // 6: 17 items through a 4-bit counter wraps to 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data = 32'h6666_0000 + i;
            @(negedge clk);
            chk("t6_ready", bus.s_ready, 1);
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
            leaf_done = N'(1) << (i % N);
            tick();
            leaf_done = '0;
        end
        tick();
        chk("t6_cnt_w4", cnt4, 1);
        chk("t6_cnt_w16", cnt, 17);
        chk("t6_err", err, 0);
        chk("t6_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
